fir_block_sequencer: RTL and testbench

- Controller that sequences one FIR12 residual filter per encoder block.
- Holds a host-writable bank of ORDER quantised LPC coefficients and clears the filter.
- Serially loads the coefficients through the filter's load port, waits a settle gap, then streams exactly BLOCK_SIZE samples into it.
- Counts returned residuals and pulses done; sits between the LPC coefficient stage and the residual coder.

---
 rtl/fir_block_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_fir_block_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_block_sequencer.sv
// Per-block sequencer for a FIR12 residual filter: coefficient bank, serial load, settle gap, sample stream, drain.
// Optional drain watchdog compiled in with `define FIR_SEQ_TIMEOUT_EN.
module fir_block_sequencer #(
  parameter int ORDER         = 12,
  parameter int COEFF_W       = 12,
  parameter int SAMPLE_W      = 16,
  parameter int BLOCK_SIZE    = 4096,
  parameter int SETTLE_CYCLES = 5,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                iClock,
  input  logic                iReset,
  input  logic                iEnable,
  input  logic                iStart,
  input  logic                iCoeffWrEn,
  input  logic [3:0]          iCoeffAddr,
  input  logic [COEFF_W-1:0]  iCoeffData,
  input  logic                iSampleValid,
  input  logic [SAMPLE_W-1:0] iSample,
  output logic                oSampleReady,
  input  logic                iResidualValid,
  output logic                oFirEnable,
  output logic                oFirReset,
  output logic                oFirLoad,
  output logic [COEFF_W-1:0]  oFirQLP,
  output logic                oFirValid,
  output logic [SAMPLE_W-1:0] oFirSample,
  output logic                oBusy,
  output logic                oDone,
  output logic                oTimeout
);

  localparam int CNT_W = $clog2(BLOCK_SIZE + 1);
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BLK_FULL = CNT_W'(BLOCK_SIZE);
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLOCK_SIZE - 1);

  if (ORDER < 1 || ORDER > 16 || BLOCK_SIZE < 1 || SETTLE_CYCLES < 1 || DRAIN_TIMEOUT < 1) begin : g_bad_params
    $error("fir_block_sequencer: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [COEFF_W-1:0]   r_bank [ORDER];
  logic [3:0]           r_k;
  logic [SET_W-1:0]     r_settle;
  logic [CNT_W-1:0]     r_sample_cnt;
  logic [CNT_W-1:0]     r_resid_cnt;
  logic                 r_sample_ready;
  logic                 r_fir_reset;
  logic                 r_fir_load;
  logic [COEFF_W-1:0]   r_fir_qlp;
  logic                 r_fir_valid;
  logic [SAMPLE_W-1:0]  r_fir_sample;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_accept;
  logic                 w_coeff_we;
  logic                 w_resid_inc;
  logic [3:0]           w_k_next;

`ifdef FIR_SEQ_TIMEOUT_EN
  localparam int DRN_W = $clog2(DRAIN_TIMEOUT + 1);
  logic [DRN_W-1:0]     r_drain_cnt;
  logic                 r_timeout;
`endif

  assign w_accept    = iEnable & iSampleValid & r_sample_ready;
  assign w_coeff_we  = iEnable & iCoeffWrEn & (r_state == S_IDLE) & ({1'b0, iCoeffAddr} < 5'(ORDER));
  assign w_resid_inc = iEnable & iResidualValid & (r_resid_cnt != BLK_FULL) &
                       ((r_state == S_STREAM) || (r_state == S_DRAIN));
  assign w_k_next    = r_k + 4'd1;

  // One register per bank slot; only reachable from IDLE, so the LOAD walk never races a write.
  for (genvar gi = 0; gi < ORDER; gi++) begin : g_bank
    always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
        r_bank[gi] <= '0;
      end else if (w_coeff_we && (iCoeffAddr == 4'(gi))) begin
        r_bank[gi] <= iCoeffData;
      end
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_state        <= S_IDLE;
      r_k            <= '0;
      r_settle       <= '0;
      r_sample_cnt   <= '0;
      r_resid_cnt    <= '0;
      r_sample_ready <= 1'b0;
      r_fir_reset    <= 1'b1;
      r_fir_load     <= 1'b0;
      r_fir_qlp      <= '0;
      r_fir_valid    <= 1'b0;
      r_fir_sample   <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
`ifdef FIR_SEQ_TIMEOUT_EN
      r_drain_cnt    <= '0;
      r_timeout      <= 1'b0;
`endif
    end else if (iEnable) begin
      r_done <= 1'b0;
      if (w_resid_inc) begin
        r_resid_cnt <= r_resid_cnt + 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_fir_reset <= 1'b1;
          r_busy      <= 1'b0;
          r_fir_valid <= 1'b0;
          if (iStart) begin
            // Filter leaves reset on the same edge that presents coefficient 0.
            r_state     <= S_LOAD;
            r_fir_reset <= 1'b0;
            r_busy      <= 1'b1;
            r_fir_load  <= 1'b1;
            r_fir_qlp   <= r_bank[0];
            r_k         <= '0;
`ifdef FIR_SEQ_TIMEOUT_EN
            r_timeout   <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (r_k == 4'(ORDER - 1)) begin
            r_state    <= S_SETTLE;
            r_fir_load <= 1'b0;
            r_fir_qlp  <= '0;
            r_settle   <= '0;
          end else begin
            r_k       <= w_k_next;
            r_fir_qlp <= r_bank[w_k_next];
          end
        end
        S_SETTLE: begin
          if (r_settle == SET_W'(SETTLE_CYCLES - 1)) begin
            r_state        <= S_STREAM;
            r_sample_ready <= 1'b1;
          end else begin
            r_settle <= r_settle + 1'b1;
          end
        end
        S_STREAM: begin
          r_fir_valid <= w_accept;
          if (w_accept) begin
            r_fir_sample <= iSample;
            r_sample_cnt <= r_sample_cnt + 1'b1;
            if (r_sample_cnt == BLK_LAST) begin
              r_sample_ready <= 1'b0;
              r_state        <= S_DRAIN;
`ifdef FIR_SEQ_TIMEOUT_EN
              r_drain_cnt    <= '0;
`endif
            end
          end
        end
        S_DRAIN: begin
          r_fir_valid <= 1'b0;
          if (r_resid_cnt == BLK_FULL) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
`ifdef FIR_SEQ_TIMEOUT_EN
          else if (r_drain_cnt == DRN_W'(DRAIN_TIMEOUT - 1)) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          r_state      <= S_IDLE;
          r_fir_reset  <= 1'b1;
          r_busy       <= 1'b0;
          r_sample_cnt <= '0;
          r_resid_cnt  <= '0;
          r_k          <= '0;
          r_settle     <= '0;
`ifdef FIR_SEQ_TIMEOUT_EN
          r_drain_cnt  <= '0;
`endif
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign oFirEnable   = iEnable;
  assign oSampleReady = r_sample_ready & iEnable;
  assign oFirReset    = r_fir_reset;
  assign oFirLoad     = r_fir_load;
  assign oFirQLP      = r_fir_qlp;
  assign oFirValid    = r_fir_valid;
  assign oFirSample   = r_fir_sample;
  assign oBusy        = r_busy;
  assign oDone        = r_done;
`ifdef FIR_SEQ_TIMEOUT_EN
  assign oTimeout     = r_timeout;
`else
  assign oTimeout     = 1'b0;
`endif

endmodule

// File: tb/tb_fir_block_sequencer.sv
// Directed/randomised bench for fir_block_sequencer with a 2-cycle-latency filter model.
module tb_fir_block_sequencer;

  localparam int ORDER    = 12;
  localparam int COEFF_W  = 12;
  localparam int SAMPLE_W = 16;
  localparam int BLOCK    = 4096;
  localparam int SETTLE   = 5;
  localparam int DT       = 64;

  logic                iClock, iReset, iEnable, iStart, iCoeffWrEn;
  logic [3:0]          iCoeffAddr;
  logic [COEFF_W-1:0]  iCoeffData;
  logic                iSampleValid;
  logic [SAMPLE_W-1:0] iSample;
  logic                oSampleReady, iResidualValid;
  logic                oFirEnable, oFirReset, oFirLoad, oFirValid;
  logic [COEFF_W-1:0]  oFirQLP;
  logic [SAMPLE_W-1:0] oFirSample;
  logic                oBusy, oDone, oTimeout;

  fir_block_sequencer #(
    .ORDER(ORDER), .COEFF_W(COEFF_W), .SAMPLE_W(SAMPLE_W),
    .BLOCK_SIZE(BLOCK), .SETTLE_CYCLES(SETTLE), .DRAIN_TIMEOUT(DT)
  ) dut (
    .iClock(iClock), .iReset(iReset), .iEnable(iEnable), .iStart(iStart),
    .iCoeffWrEn(iCoeffWrEn), .iCoeffAddr(iCoeffAddr), .iCoeffData(iCoeffData),
    .iSampleValid(iSampleValid), .iSample(iSample), .oSampleReady(oSampleReady),
    .iResidualValid(iResidualValid), .oFirEnable(oFirEnable), .oFirReset(oFirReset),
    .oFirLoad(oFirLoad), .oFirQLP(oFirQLP), .oFirValid(oFirValid), .oFirSample(oFirSample),
    .oBusy(oBusy), .oDone(oDone), .oTimeout(oTimeout)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [COEFF_W-1:0] exp_bank [ORDER];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClock);
    #1;
    cyc++;
  endtask

  task automatic write_coeff(input logic [3:0] addr, input logic [COEFF_W-1:0] data);
    iCoeffWrEn = 1'b1;
    iCoeffAddr = addr;
    iCoeffData = data;
    tick();
    iCoeffWrEn = 1'b0;
  endtask

  task automatic clear_model_bank();
    for (int k = 0; k < ORDER; k++) exp_bank[k] = '0;
  endtask

  task automatic start_and_load();
    int n;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    chk("timeout_cleared_on_start", oTimeout, 0);
    for (int k = 0; k < ORDER; k++) begin
      chk("load_high", oFirLoad, 1);
      chk("load_qlp", oFirQLP, exp_bank[k]);
      chk("load_fir_reset_low", oFirReset, 0);
      chk("load_busy", oBusy, 1);
      tick();
    end
    n = 0;
    while (!oSampleReady && n < 50) begin
      chk("settle_quiet", {oFirLoad, oFirValid}, 0);
      n++;
      tick();
    end
    chk("settle_len", n, SETTLE);
    $display("block loaded: %0d coefficients, settle %0d cycles", ORDER, n);
  endtask

  // mode 0: source always valid, 1: valid on alternate cycles.
  // reset_at/inject_at count accepted samples; freeze_at counts cycles from stream start; -1 disables.
  task automatic run_stream(input int mode, input bit drop_last, input int reset_at,
                            input int inject_at, input int freeze_at);
    int acc, res, last_res, drain_entry, start;
    bit exp_fv, fv_d1, fv_d2, fv_now, en, valid, rv, accept, exp_done, exp_to, exp_ready;
    logic [SAMPLE_W-1:0] exp_fs, smp;
    acc = 0; res = 0; last_res = -1000; drain_entry = -1; start = cyc;
    exp_fv = 0; exp_fs = '0; fv_d1 = 0; fv_d2 = 0;
    forever begin
      fv_now = oFirValid;
      chk("fir_valid", oFirValid, exp_fv);
      if (exp_fv) chk("fir_sample", oFirSample, exp_fs);
      exp_done = (res == BLOCK) && (cyc == last_res + 2);
      exp_to   = 1'b0;
`ifdef FIR_SEQ_TIMEOUT_EN
      if (drop_last && drain_entry >= 0) begin
        exp_done = (cyc == drain_entry + DT);
        exp_to   = (cyc >= drain_entry + DT);
      end
`endif
      chk("done", oDone, exp_done);
      chk("timeout", oTimeout, exp_to);
      if (oDone) begin
        tick();
        chk("idle_busy", oBusy, 0);
        chk("idle_fir_reset", oFirReset, 1);
        chk("idle_ready", oSampleReady, 0);
        chk("idle_timeout", oTimeout, exp_to);
        $display("block done: %0d accepted, %0d residuals, timeout=%0d", acc, res, oTimeout);
        return;
      end
`ifndef FIR_SEQ_TIMEOUT_EN
      if (drop_last && drain_entry >= 0 && cyc == drain_entry + 100) begin
        chk("drain_waits_busy", oBusy, 1);
        $display("block stalled in drain as expected: %0d accepted, %0d residuals", acc, res);
        return;
      end
`endif
      if (cyc - start > 3 * BLOCK + 300) begin
        chk("stream_cycle_bound", 0, 1);
        return;
      end
      if (reset_at >= 0 && acc == reset_at) begin
        iReset = 1'b1;
        tick();
        chk("midreset_fir_reset", oFirReset, 1);
        chk("midreset_busy", oBusy, 0);
        chk("midreset_ready", oSampleReady, 0);
        chk("midreset_fir_valid", oFirValid, 0);
        iReset = 1'b0;
        clear_model_bank();
        $display("mid-block reset after %0d samples", acc);
        return;
      end
      en    = !(freeze_at >= 0 && (cyc - start) >= freeze_at && (cyc - start) < freeze_at + 4);
      valid = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
      smp   = SAMPLE_W'($urandom);
      rv    = en && fv_d2 && !(drop_last && res == BLOCK - 1);
      exp_ready      = (acc < BLOCK);
      iEnable        = en;
      iSampleValid   = valid;
      iSample        = smp;
      iResidualValid = rv;
      if (inject_at >= 0 && acc == inject_at) begin
        iCoeffWrEn = 1'b1;
        iCoeffAddr = 4'd3;
        iCoeffData = COEFF_W'(777);
        iStart     = 1'b1;
      end
      #1;
      chk("sample_ready", oSampleReady, exp_ready && en);
      chk("fir_enable", oFirEnable, en);
      accept = en && valid && exp_ready;
      tick();
      iCoeffWrEn = 1'b0;
      iStart     = 1'b0;
      if (en) begin
        exp_fv = accept;
        if (accept) begin
          exp_fs = smp;
          acc++;
          if (acc == BLOCK) drain_entry = cyc;
        end
        if (rv) begin
          res++;
          last_res = cyc - 1;
        end
        fv_d2 = fv_d1;
        fv_d1 = fv_now;
      end
    end
  endtask

  localparam logic signed [COEFF_W-1:0] TP_BANK [ORDER] = '{
    -12'sd206, 12'sd116, 12'sd131, 12'sd140, 12'sd136, -12'sd54,
    -12'sd281, -12'sd134, -12'sd517, 12'sd416, -12'sd154, 12'sd1427
  };

  initial begin
    iReset = 1'b1; iEnable = 1'b1; iStart = 1'b0; iCoeffWrEn = 1'b0;
    iCoeffAddr = '0; iCoeffData = '0; iSampleValid = 1'b0; iSample = '0;
    iResidualValid = 1'b0;
    clear_model_bank();
    tick(); tick();
    chk("rst_fir_reset", oFirReset, 1);
    chk("rst_busy", oBusy, 0);
    chk("rst_done", oDone, 0);
    chk("rst_load", oFirLoad, 0);
    chk("rst_qlp", oFirQLP, 0);
    chk("rst_valid", oFirValid, 0);
    chk("rst_ready", oSampleReady, 0);
    chk("rst_timeout", oTimeout, 0);
    iReset = 1'b0;
    tick();

    // Block A: test-plan bank, continuous source
    for (int k = 0; k < ORDER; k++) begin
      exp_bank[k] = TP_BANK[k];
      write_coeff(4'(k), TP_BANK[k]);
    end
    write_coeff(4'd12, COEFF_W'(55));
    start_and_load();
    run_stream(0, 1'b0, -1, -1, -1);

    // Block B: gapped source, bank write and iStart while streaming
    start_and_load();
    run_stream(1, 1'b0, -1, 100, -1);

    // Block C: bank must be unchanged; reset at sample 1000
    start_and_load();
    run_stream(0, 1'b0, 1000, -1, -1);

    // Block D: all-zero reload, final residual dropped
    tick();
    start_and_load();
    run_stream(0, 1'b1, -1, -1, -1);
`ifndef FIR_SEQ_TIMEOUT_EN
    iReset = 1'b1;
    tick();
    iReset = 1'b0;
    clear_model_bank();
    tick();
`endif

    // Block E: random bank, enable freeze mid-stream
    for (int k = 0; k < ORDER; k++) begin
      exp_bank[k] = COEFF_W'($urandom);
      write_coeff(4'(k), exp_bank[k]);
    end
    start_and_load();
    run_stream(0, 1'b0, -1, -1, 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
